multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the multicycle RISC-V datapath: fetch, decode, execute, memory access and writeback.
- Decodes OP/Funct3/Funct7 from the instruction register and drives mux selects, ULA operation and write enables one state at a time.
- Supported instructions: ADD, SUB, AND, OR, XOR, SLT, ADDI, ANDI, ORI, XORI, SLTI, LW, SW, BEQ.
- Sits between the instruction register and the shared instruction/data memory, register file, ULA and PC register.

Parameters:
- WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until MemReady is high; 0 = MemReady ignored (treated as 1).

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST_N  input  1  synchronous active-low reset
- OP  input  7  opcode field from instruction register
- Funct3  input  3  funct3 field from instruction register
- Funct7  input  7  funct7 field from instruction register
- Zero  input  1  ULA zero flag
- MemReady  input  1  memory access completes this cycle
- PCWrite  output  1  PC register load enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register and OldPC load enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ULA result
- ULASrcA  output  2  ULA A select: 00 = PC, 01 = OldPC, 10 = rs1
- ULASrcB  output  2  ULA B select: 00 = rs2, 01 = immediate, 10 = constant 4
- ImmSrc  output  2  immediate type: 00 = I, 01 = S, 10 = B
- RegWrite  output  1  register file write enable
- ULAControl  output  3  ULA operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- Illegal  output  1  sticky illegal-instruction flag
- State  output  4  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, ILLEGAL=15.
- Reset: at a rising CLK edge with RST_N=0, state goes to FETCH. While RST_N=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Outputs are a pure decode of state plus the IR fields and Zero. Any output not listed for a state takes its default, which is 0 (every multi-bit field is all-zero).
- FETCH: ULASrcB=10, ResultSrc=10, IRWrite=PCWrite=MemReady. Stay while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ULASrcA=01, ULASrcB=01, ImmSrc=10 (branch target into ALUOut). Next state by OP:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 with Funct3=000 -> BEQ
  - anything else -> ILLEGAL
- MEMADR: ULASrcA=10, ULASrcB=01, ImmSrc=00 for LW, 01 for SW. LW -> MEMREAD; SW -> MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle spent in the state. Go to FETCH on the cycle MemReady=1.
- EXECR: ULASrcA=10, ULASrcB=00. Funct3/Funct7 map as follows, then go to ALUWB:
  - 000/0000000 add
  - 000/0100000 sub
  - 111/0000000 and
  - 110/0000000 or
  - 100/0000000 xor
  - 010/0000000 slt
  - any other pair -> ILLEGAL; no write occurs
- EXECI: ULASrcA=10, ULASrcB=01, ImmSrc=00. Funct3 map (Funct7 ignored), then go to ALUWB:
  - 000 add
  - 111 and
  - 110 or
  - 100 xor
  - 010 slt
  - other -> ILLEGAL
- ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
- BEQ: ULASrcA=10, ULASrcB=00, ULAControl=001, ResultSrc=00, PCWrite=Zero, then go to FETCH.
- ILLEGAL: all enables 0 and Illegal=1. Absorbing state; only reset leaves it.
- Latency per instruction with MemReady=1 throughout:
  - R/I-type and LW: 4 cycles and 5 cycles respectively (LW adds MEMREAD).
  - SW: 4 cycles.
  - BEQ: 3 cycles.
- Every MemReady=0 cycle in a wait state adds one cycle.
- Write enables never overlap: at most one of MemWrite and RegWrite is high in any cycle.
- Reset mid-instruction: any partially executed instruction is abandoned. No write enable is asserted on the cycle RST_N is low.

Optional Feature:
- Macro INSTR_COUNT_EN.
- When defined: adds output InstrRetired[31:0].
  - Cleared by reset.
  - Increments by 1 on each edge where the FSM leaves MEMWB, MEMWRITE (MemReady=1), ALUWB or BEQ for FETCH.
  - Wraps from 0xFFFFFFFF to 0.
  - Does not increment in ILLEGAL.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset hold 2 cycles, then MemReady=1 with OP=0110011, F3=000, F7=0100000:
  - State sequence 0,1,6,8,0.
  - ULAControl=001 in EXECR; RegWrite=1 only in ALUWB.
- LW (OP=0000011) with MemReady low for 3 cycles in MEMREAD:
  - State stays 3 for 3 cycles, then goes to 4.
  - ResultSrc=01 and RegWrite=1 in MEMWB; total 8 cycles.
- SW (OP=0100011):
  - ImmSrc=01 in MEMADR.
  - MemWrite=1 exactly in MEMWRITE cycles; RegWrite never high.
- BEQ with Zero=1, then BEQ with Zero=0:
  - PCWrite=1 in the BEQ state only for the first.
  - PCWrite=1 in FETCH for both.
- OP=1111111 in DECODE, then EXECR with F3=001:
  - Both enter state 15 and Illegal=1 held for 10 cycles.
  - Exit only after RST_N=0 at an edge.
- RST_N low during MEMWRITE: MemWrite drops that cycle and the next state is FETCH. With INSTR_COUNT_EN defined, InstrRetired reads 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: R/I-type 4, LW 5, SW 4, BEQ 3 cycles; each MemReady=0 cycle in a wait state adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while MemReady=0 (when WAIT_EN=1).
//
// Optional feature: define INSTR_COUNT_EN to add the InstrRetired[31:0] retired-instruction counter.
//
// Ports: CLK/RST_N (sync active-low reset); OP/Funct3/Funct7 from the IR; Zero from the ULA;
// MemReady from memory. Outputs are mux selects, ULA op and write enables decoded from the
// current state; Illegal flags the absorbing illegal state; State exposes the FSM for debug.
module multicycle_control_unit #(
    parameter logic WAIT_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [6:0]  OP,
    input  logic [2:0]  Funct3,
    input  logic [6:0]  Funct7,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ULASrcA,
    output logic [1:0]  ULASrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [2:0]  ULAControl,
    output logic        Illegal,
    output logic [3:0]  State
`ifdef INSTR_COUNT_EN
    ,
    output logic [31:0] InstrRetired
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    state_t     state;
    logic       mem_rdy;
    logic [2:0] r_uc;
    logic [2:0] i_uc;
    logic       r_ok;
    logic       i_ok;

    // With waiting disabled the memory is assumed to always complete in one cycle.
    assign mem_rdy = WAIT_EN ? MemReady : 1'b1;
    assign State   = state;

    // R-type funct decode; unsupported pairs send the FSM to ILLEGAL before any write.
    always_comb begin
        r_ok = 1'b1;
        r_uc = 3'b000;
        case ({Funct3, Funct7})
            {3'b000, 7'b0000000}: r_uc = 3'b000;
            {3'b000, 7'b0100000}: r_uc = 3'b001;
            {3'b111, 7'b0000000}: r_uc = 3'b010;
            {3'b110, 7'b0000000}: r_uc = 3'b011;
            {3'b100, 7'b0000000}: r_uc = 3'b100;
            {3'b010, 7'b0000000}: r_uc = 3'b101;
            default:              r_ok = 1'b0;
        endcase
    end

    // I-type decode ignores Funct7 (it is part of the immediate).
    always_comb begin
        i_ok = 1'b1;
        i_uc = 3'b000;
        case (Funct3)
            3'b000:  i_uc = 3'b000;
            3'b111:  i_uc = 3'b010;
            3'b110:  i_uc = 3'b011;
            3'b100:  i_uc = 3'b100;
            3'b010:  i_uc = 3'b101;
            default: i_ok = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    case (OP)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECR;
                        OP_I:         state <= S_EXECI;
                        OP_BR:        state <= (Funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
                        default:      state <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: begin
                    if (OP == OP_LW)      state <= S_MEMREAD;
                    else if (OP == OP_SW) state <= S_MEMWRITE;
                    else                  state <= S_ILLEGAL;
                end
                S_MEMREAD:  if (mem_rdy) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (mem_rdy) state <= S_FETCH;
                S_EXECR:    state <= r_ok ? S_ALUWB : S_ILLEGAL;
                S_EXECI:    state <= i_ok ? S_ALUWB : S_ILLEGAL;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                default:    state <= S_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ULASrcA    = 2'b00;
        ULASrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegWrite   = 1'b0;
        ULAControl = 3'b000;
        Illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                // PC+4 goes straight from the ULA into the PC as the instruction lands.
                ULASrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_rdy;
                PCWrite   = mem_rdy;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ULASrcA = 2'b01;
                ULASrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            S_MEMADR: begin
                ULASrcA = 2'b10;
                ULASrcB = 2'b01;
                ImmSrc  = (OP == OP_SW) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ULASrcA    = 2'b10;
                ULAControl = r_uc;
            end
            S_EXECI: begin
                ULASrcA    = 2'b10;
                ULASrcB    = 2'b01;
                ULAControl = i_uc;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ULASrcA    = 2'b10;
                ULAControl = 3'b001;
                PCWrite    = Zero;
            end
            S_ILLEGAL: Illegal = 1'b1;
            default:   Illegal = 1'b1;
        endcase
        // Nothing may be written while reset is asserted, whatever state we are in.
        if (!RST_N) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

`ifdef INSTR_COUNT_EN
    logic retire;

    assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                    ((state == S_MEMWRITE) && mem_rdy);

    always_ff @(posedge CLK) begin
        if (!RST_N)      InstrRetired <= 32'd0;
        else if (retire) InstrRetired <= InstrRetired + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected state/controls are queued
// as each cycle's inputs are applied and compared on the falling edge.
// Runs a fixed cycle schedule; no open-ended waits.
module tb_multicycle_control_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [6:0]  OP;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0]  ResultSrc, ULASrcA, ULASrcB, ImmSrc;
    logic [2:0]  ULAControl;
    logic [3:0]  State;
`ifdef INSTR_COUNT_EN
    logic [31:0] InstrRetired;
`endif

    always #5 CLK = ~CLK;

    multicycle_control_unit dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .OP         (OP),
        .Funct3     (Funct3),
        .Funct7     (Funct7),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ULASrcA    (ULASrcA),
        .ULASrcB    (ULASrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .ULAControl (ULAControl),
        .Illegal    (Illegal),
        .State      (State)
`ifdef INSTR_COUNT_EN
        ,
        .InstrRetired (InstrRetired)
`endif
    );

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BEQ = 4'd9, S_ILLEGAL = 4'd15;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        cnt_vld;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    logic [6:0]  op_v;
    logic [2:0]  f3_v;
    logic [6:0]  f7_v;
    logic [16:0] got_ctl;
    logic [16:0] C_FETCH0, C_FETCH1, C_DEC, C_ADR_LW, C_ADR_SW, C_MRD, C_MWB, C_MWR, C_AWB, C_ILL;

    assign got_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ULASrcA, ULASrcB, ImmSrc,
                      RegWrite, ULAControl, Illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm, input logic rw,
                                       input logic [2:0] uc, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, uc, ill};
    endfunction

    function automatic logic [16:0] exr(input logic [2:0] uc);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, uc, 1'b0);
    endfunction

    function automatic logic [16:0] exi(input logic [2:0] uc);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, uc, 1'b0);
    endfunction

    function automatic logic [16:0] beq(input logic z);
        return mk(z, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 3'd1, 1'b0);
    endfunction

    // Apply one cycle's inputs just after the rising edge and queue what the DUT should show.
    task automatic drive(input logic rst, input logic rdy, input logic z, input logic [3:0] st,
                         input logic [16:0] ctl, input logic cv, input logic [31:0] cnt);
        exp_t e;
        @(posedge CLK);
        #1;
        RST_N    = rst;
        MemReady = rdy;
        Zero     = z;
        OP       = op_v;
        Funct3   = f3_v;
        Funct7   = f7_v;
        e.st      = st;
        e.ctl     = ctl;
        e.cnt_vld = cv;
        e.cnt     = cnt;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic z, input logic [3:0] st,
                       input logic [16:0] ctl);
        drive(rst, rdy, z, st, ctl, 1'b0, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cyc_n++;
            check($sformatf("state c%0d", cyc_n), {28'd0, State}, {28'd0, e.st});
            check($sformatf("ctl c%0d", cyc_n), {15'd0, got_ctl}, {15'd0, e.ctl});
`ifdef INSTR_COUNT_EN
            if (e.cnt_vld) check($sformatf("retired c%0d", cyc_n), InstrRetired, e.cnt);
`endif
        end
    end

    initial begin
        RST_N = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        OP = 7'd0; Funct3 = 3'd0; Funct7 = 7'd0;
        C_FETCH0 = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0);
        C_FETCH1 = mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 3'd0, 1'b0);
        C_DEC    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2, 1'b0, 3'd0, 1'b0);
        C_ADR_LW = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 1'b0, 3'd0, 1'b0);
        C_ADR_SW = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd1, 1'b0, 3'd0, 1'b0);
        C_MRD    = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
        C_MWB    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0);
        C_MWR    = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0);
        C_AWB    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0);
        C_ILL    = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b1);

        // Reset held two cycles: FETCH with all enables suppressed.
        op_v = OP_R; f3_v = 3'b000; f7_v = 7'b0100000;
        cyc(1'b0, 1'b1, 1'b0, S_FETCH, C_FETCH0);
        cyc(1'b0, 1'b1, 1'b0, S_FETCH, C_FETCH0);

        // SUB: 0,1,6,8
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_EXECR, exr(3'd1));
        cyc(1'b1, 1'b1, 1'b0, S_ALUWB, C_AWB);

        // LW with three stall cycles in MEMREAD: 8 cycles total.
        op_v = OP_LW; f3_v = 3'b010; f7_v = 7'd0;
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_MEMADR, C_ADR_LW);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, S_MEMREAD, C_MRD);
        cyc(1'b1, 1'b1, 1'b0, S_MEMREAD, C_MRD);
        cyc(1'b1, 1'b1, 1'b0, S_MEMWB, C_MWB);

        // SW with one stall cycle in MEMWRITE.
        op_v = OP_SW;
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_MEMADR, C_ADR_SW);
        cyc(1'b1, 1'b0, 1'b0, S_MEMWRITE, C_MWR);
        cyc(1'b1, 1'b1, 1'b0, S_MEMWRITE, C_MWR);

        // XORI: Funct7 bits are immediate and must not matter.
        op_v = OP_I; f3_v = 3'b100; f7_v = 7'h7f;
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_EXECI, exi(3'd4));
        cyc(1'b1, 1'b1, 1'b0, S_ALUWB, C_AWB);

        // AND with a fetch stall.
        op_v = OP_R; f3_v = 3'b111; f7_v = 7'd0;
        cyc(1'b1, 1'b0, 1'b0, S_FETCH, C_FETCH0);
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_EXECR, exr(3'd2));
        cyc(1'b1, 1'b1, 1'b0, S_ALUWB, C_AWB);

        // BEQ taken, then not taken.
        op_v = OP_BR; f3_v = 3'b000;
        cyc(1'b1, 1'b1, 1'b1, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b1, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b1, S_BEQ, beq(1'b1));
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_BEQ, beq(1'b0));

        // SW abandoned by reset in MEMWRITE (MemReady high, so reset must beat retirement).
        op_v = OP_SW; f3_v = 3'b010;
        drive(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1, 1'b1, 32'd7);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_MEMADR, C_ADR_SW);
        cyc(1'b0, 1'b1, 1'b0, S_MEMWRITE, C_MRD);

        // Unknown opcode: absorbed in ILLEGAL until reset.
        op_v = 7'b1111111;
        drive(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1, 1'b1, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        for (int i = 0; i < 10; i++) cyc(1'b1, i[0], 1'b1, S_ILLEGAL, C_ILL);
        cyc(1'b0, 1'b1, 1'b0, S_ILLEGAL, C_ILL);

        // R-type with unsupported funct3: EXECR then ILLEGAL, no register write.
        op_v = OP_R; f3_v = 3'b001; f7_v = 7'd0;
        cyc(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1);
        cyc(1'b1, 1'b1, 1'b0, S_DECODE, C_DEC);
        cyc(1'b1, 1'b1, 1'b0, S_EXECR, exr(3'd0));
        for (int i = 0; i < 10; i++) cyc(1'b1, i[0], 1'b1, S_ILLEGAL, C_ILL);
        cyc(1'b0, 1'b1, 1'b0, S_ILLEGAL, C_ILL);
        drive(1'b1, 1'b1, 1'b0, S_FETCH, C_FETCH1, 1'b1, 32'd0);

        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) check("queue drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
